// File: rtl/enc_pkg.sv
// enc_pkg: shared constants, buffer entry layout and occupancy states for the one-hot encoder.
package enc_pkg;
   localparam int N_DEF        = 4;
   localparam int ERRCNT_W_DEF = 8;
   localparam int CODE_MAX_W   = 8;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [CODE_MAX_W-1:0] code;
      logic                  err;
   } entry_t;
endpackage

// File: rtl/enc_onehot_core.sv
// enc_onehot_core: combinational N-to-log2(N) encoder producing {code, err}.
// ENC_PRIORITY_EN selects lowest-set-bit resolution of multi-hot words instead of flagging them.
module enc_onehot_core
   import enc_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0] onehot,
   output entry_t       ent
);
   logic [CODE_MAX_W-1:0] idx;
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) idx = onehot[i] ? CODE_MAX_W'(i) : idx;
   end
`ifdef ENC_PRIORITY_EN
   assign ent.code = idx;
   assign ent.err  = ~|onehot;
`else
   logic single;
   // x & (x-1) clears the lowest set bit; zero result means at most one bit was set
   assign single   = |onehot && ~|(onehot & (onehot - N'(1)));
   assign ent.code = single ? idx : '0;
   assign ent.err  = ~single;
`endif
endmodule

// File: rtl/enc_onehot_to_bin_buf.sv
// enc_onehot_to_bin_buf: one-hot to binary encoder behind a 2-entry valid/ready buffer
// with a saturating illegal-input counter; build option ENC_PRIORITY_EN (see enc_onehot_core).
module enc_onehot_to_bin_buf
   import enc_pkg::*;
#(
   parameter  int N        = N_DEF,
   parameter  int ERRCNT_W = ERRCNT_W_DEF,
   localparam int W        = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_onehot,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_code,
   output logic                out_err,
   input  logic                clr_err,
   output logic [ERRCNT_W-1:0] err_count
);
   state_t state, state_d;
   entry_t head, tail, enc;
   logic   push, pop;
   logic   unused_code;
   enc_onehot_core #(.N(N)) u_core (.onehot(in_onehot), .ent(enc));
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign unused_code = ^head.code;
   // in_ready is registered from the next state so it never depends on out_ready combinationally
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_d;
         in_ready <= state_d != TWO;
      end
   always_comb begin
      state_d = state;
      case (state)
         EMPTY:   state_d = push ? ONE : EMPTY;
         ONE:     state_d = (push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE;
         TWO:     state_d = pop ? ONE : TWO;
         default: state_d = EMPTY;
      endcase
   end
   always_comb begin
      out_valid = state != EMPTY;
      out_code  = head.code[W-1:0];
      out_err   = head.err;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push && (state == EMPTY || pop)) head <= enc;
         else if (pop) head <= tail;
         if (push && !pop && state == ONE) tail <= enc;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_count <= '0;
      else if (clr_err) err_count <= '0;
      else if (push && enc.err && err_count != '1) err_count <= err_count + ERRCNT_W'(1);
endmodule

// File: tb/tb_enc_onehot_to_bin_buf.sv
// tb_enc_onehot_to_bin_buf: queue-based reference model compared every cycle, plus literal checks.
module tb_enc_onehot_to_bin_buf;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_onehot = '0;
   logic       out_ready = 1'b0;
   logic       clr_err = 1'b0;
   logic       in_ready, out_valid, out_err;
   logic [1:0] out_code;
   logic [7:0] err_count;
   logic       in_ready2, out_valid2, out_err2;
   logic [1:0] out_code2;
   logic [1:0] err_count2;
   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   typedef struct {int code; bit err;} ent_t;
   ent_t q[$];
   int cnt8 = 0;
   int cnt2 = 0;

   always #5 clk = ~clk;

   enc_onehot_to_bin_buf #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_onehot(in_onehot), .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .out_err(out_err), .clr_err(clr_err), .err_count(err_count));

   enc_onehot_to_bin_buf #(.N(4), .ERRCNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_onehot(in_onehot), .out_valid(out_valid2), .out_ready(out_ready),
      .out_code(out_code2), .out_err(out_err2), .clr_err(clr_err), .err_count(err_count2));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic ent_t enc(input logic [3:0] v);
      ent_t e;
      e.code = 0;
      e.err  = 1'b0;
      if (v == 0) e.err = 1'b1;
      else if ($countones(v) == 1) e.code = $clog2(v);
      else begin
`ifdef ENC_PRIORITY_EN
         e.code = $clog2(v & (~v + 4'd1));
`else
         e.err = 1'b1;
`endif
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q.delete();
         cnt8 = 0;
         cnt2 = 0;
      end else begin
         bit push, pop;
         ent_t e;
         push = in_valid && q.size() < 2;
         pop  = q.size() > 0 && out_ready;
         e    = enc(in_onehot);
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
         if (clr_err) begin
            cnt8 = 0;
            cnt2 = 0;
         end else if (push && e.err) begin
            cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
            cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
         end
      end

   always @(negedge clk)
      if (rst_n && chk_en) begin
         check("in_ready", in_ready, q.size() < 2);
         check("out_valid", out_valid, q.size() > 0);
         check("in_ready2", in_ready2, q.size() < 2);
         if (q.size() > 0) begin
            check("out_code", out_code, q[0].code);
            check("out_err", out_err, q[0].err);
            check("out_code2", out_code2, q[0].code);
         end
         check("err_count", err_count, cnt8);
         check("err_count2", err_count2, cnt2);
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sat_exp[5] = '{1, 2, 3, 3, 3};
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_code", out_code, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_count", err_count, 0);

      // back-to-back legal beats
      step();
      in_valid = 1'b1; in_onehot = 4'b0001; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) in_onehot = 4'b0010 << k;
         else in_valid = 1'b0;
         @(negedge clk);
         check("b2b_code", out_code, k);
         check("b2b_valid", out_valid, 1);
         check("b2b_err", out_err, 0);
      end
      step();
      check("b2b_err_count", err_count, 0);

      // back-pressure
      out_ready = 1'b0; in_valid = 1'b1; in_onehot = 4'b0100;
      step();
      in_onehot = 4'b1000;
      step();
      in_onehot = 4'b0001;
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      step();
      step();
      check("bp_hold_code", out_code, 2);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_head2", out_code, 2);
      step();
      @(negedge clk);
      check("bp_in_ready_up", in_ready, 1);
      check("bp_head3", out_code, 3);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_head0", out_code, 0);
      step();
      @(negedge clk);
      check("bp_empty", out_valid, 0);

      // illegal inputs
      in_valid = 1'b1; in_onehot = 4'b0000;
      step();
      in_onehot = 4'b0110;
      @(negedge clk);
      check("zero_code", out_code, 0);
      check("zero_err", out_err, 1);
      check("zero_count", err_count, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
`ifdef ENC_PRIORITY_EN
      check("multi_code", out_code, 1);
      check("multi_err", out_err, 0);
      check("multi_count", err_count, 1);
`else
      check("multi_code", out_code, 0);
      check("multi_err", out_err, 1);
      check("multi_count", err_count, 2);
`endif

      // saturation on the 2-bit counter, then clear beating a same-cycle increment
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0; in_valid = 1'b1; in_onehot = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 4) clr_err = 1'b1;
         @(negedge clk);
         check("sat_count2", err_count2, sat_exp[k]);
      end
      step();
      clr_err = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("clr_prio2", err_count2, 0);
      check("clr_prio8", err_count, 0);

      // async reset while full
      out_ready = 1'b0; in_valid = 1'b1; in_onehot = 4'b0000;
      step();
      in_onehot = 4'b0010;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_count", err_count, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_err_count", err_count, 0);
      step();
      rst_n = 1'b1; in_valid = 1'b1; in_onehot = 4'b1000; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_code", out_code, 3);
      check("post_rst_valid", out_valid, 1);

      // random handshake traffic with legal one-hot words
      for (int c = 0; c < 1000; c++) begin
         step();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_onehot = 4'b0001 << $urandom_range(0, 3);
      end
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      check("drain_empty", out_valid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
